// File: rtl/power_sequencer.sv
// Power-domain sequencer: walks one switchable domain through clock gating,
// isolation, retention save/restore and power-switch handshakes.
module power_sequencer #(
    parameter int unsigned STEP_CYCLES = 2,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] power_mode,
    input  logic       pwr_ack,
    output logic       clk_en,
    output logic       iso_en,
    output logic       save,
    output logic       restore,
    output logic       pwr_req,
    output logic       seq_busy,
    output logic [1:0] domain_state,
    output logic       err
);

    localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned TMO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] MODE_IDLE  = 2'b01;
    localparam logic [1:0] MODE_SLEEP = 2'b10;

    localparam logic [3:0] ST_RUN     = 4'd0;
    localparam logic [3:0] ST_GATED   = 4'd1;
    localparam logic [3:0] ST_ISO_ON  = 4'd2;
    localparam logic [3:0] ST_SAVE    = 4'd3;
    localparam logic [3:0] ST_PWR_DN  = 4'd4;
    localparam logic [3:0] ST_OFF     = 4'd5;
    localparam logic [3:0] ST_PWR_UP  = 4'd6;
    localparam logic [3:0] ST_RESTORE = 4'd7;
    localparam logic [3:0] ST_ISO_OFF = 4'd8;

    localparam logic [1:0] DOM_RUN   = 2'b00;
    localparam logic [1:0] DOM_GATED = 2'b01;
    localparam logic [1:0] DOM_OFF   = 2'b10;
    localparam logic [1:0] DOM_TRANS = 2'b11;

    logic [3:0]        state;
    logic [3:0]        state_nxt;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_cnt_nxt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_cnt_nxt;
    logic              step_done;
    logic              in_wait;

    logic       clk_en_nxt;
    logic       iso_en_nxt;
    logic       save_nxt;
    logic       restore_nxt;
    logic       pwr_req_nxt;
    logic       seq_busy_nxt;
    logic [1:0] domain_state_nxt;
    logic       err_nxt;

    // Steady-state destination for a sampled mode; 11 behaves as ACTIVE.
    function automatic logic [3:0] mode_target(input logic [1:0] mode);
        logic [3:0] tgt;
        tgt = ST_RUN;
        if (mode == MODE_IDLE) begin
            tgt = ST_GATED;
        end else if (mode == MODE_SLEEP) begin
            tgt = ST_ISO_ON;
        end
        return tgt;
    endfunction

    // State register plus the registered copies of every output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            step_cnt     <= '0;
            tmo_cnt      <= '0;
            clk_en       <= 1'b1;
            iso_en       <= 1'b0;
            save         <= 1'b0;
            restore      <= 1'b0;
            pwr_req      <= 1'b1;
            seq_busy     <= 1'b0;
            domain_state <= DOM_RUN;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            step_cnt     <= step_cnt_nxt;
            tmo_cnt      <= tmo_cnt_nxt;
            clk_en       <= clk_en_nxt;
            iso_en       <= iso_en_nxt;
            save         <= save_nxt;
            restore      <= restore_nxt;
            pwr_req      <= pwr_req_nxt;
            seq_busy     <= seq_busy_nxt;
            domain_state <= domain_state_nxt;
            err          <= err_nxt;
        end
    end

    // Next-state, counters, sticky error and next-output decode.
    always_comb begin
        state_nxt        = state;
        step_cnt_nxt     = step_cnt;
        tmo_cnt_nxt      = tmo_cnt;
        err_nxt          = err;
        clk_en_nxt       = 1'b1;
        iso_en_nxt       = 1'b0;
        save_nxt         = 1'b0;
        restore_nxt      = 1'b0;
        pwr_req_nxt      = 1'b1;
        seq_busy_nxt     = 1'b0;
        domain_state_nxt = DOM_RUN;
        step_done        = (step_cnt == STEP_LAST);
        in_wait          = (state == ST_PWR_DN) || (state == ST_PWR_UP);

        case (state)
            ST_RUN:     state_nxt = mode_target(power_mode);
            ST_GATED:   state_nxt = mode_target(power_mode);
            ST_ISO_ON:  if (step_done) state_nxt = ST_SAVE;
            ST_SAVE:    if (step_done) state_nxt = ST_PWR_DN;
            ST_PWR_DN:  if (!pwr_ack) state_nxt = ST_OFF;
            ST_OFF:     if (power_mode != MODE_SLEEP) state_nxt = ST_PWR_UP;
            ST_PWR_UP:  if (pwr_ack) state_nxt = ST_RESTORE;
            ST_RESTORE: if (step_done) state_nxt = ST_ISO_OFF;
            ST_ISO_OFF: if (step_done) state_nxt = mode_target(power_mode);
            default:    state_nxt = ST_RUN;
        endcase

        // Both counters restart on every state entry; the timeout one saturates.
        if (state_nxt != state) begin
            step_cnt_nxt = '0;
            tmo_cnt_nxt  = '0;
        end else begin
            if (!step_done) begin
                step_cnt_nxt = step_cnt + STEP_W'(1);
            end
            if (in_wait) begin
                if (tmo_cnt == TMO_LAST) begin
                    err_nxt = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end
        end

        case (state_nxt)
            ST_GATED: begin
                clk_en_nxt       = 1'b0;
                domain_state_nxt = DOM_GATED;
            end
            ST_ISO_ON: begin
                clk_en_nxt       = 1'b0;
                iso_en_nxt       = 1'b1;
                seq_busy_nxt     = 1'b1;
                domain_state_nxt = DOM_TRANS;
            end
            ST_SAVE: begin
                clk_en_nxt       = 1'b0;
                iso_en_nxt       = 1'b1;
                save_nxt         = 1'b1;
                seq_busy_nxt     = 1'b1;
                domain_state_nxt = DOM_TRANS;
            end
            ST_PWR_DN: begin
                clk_en_nxt       = 1'b0;
                iso_en_nxt       = 1'b1;
                pwr_req_nxt      = 1'b0;
                seq_busy_nxt     = 1'b1;
                domain_state_nxt = DOM_TRANS;
            end
            ST_OFF: begin
                clk_en_nxt       = 1'b0;
                iso_en_nxt       = 1'b1;
                pwr_req_nxt      = 1'b0;
                domain_state_nxt = DOM_OFF;
            end
            ST_PWR_UP: begin
                clk_en_nxt       = 1'b0;
                iso_en_nxt       = 1'b1;
                seq_busy_nxt     = 1'b1;
                domain_state_nxt = DOM_TRANS;
            end
            ST_RESTORE: begin
                clk_en_nxt       = 1'b0;
                iso_en_nxt       = 1'b1;
                restore_nxt      = 1'b1;
                seq_busy_nxt     = 1'b1;
                domain_state_nxt = DOM_TRANS;
            end
            ST_ISO_OFF: begin
                clk_en_nxt       = 1'b0;
                seq_busy_nxt     = 1'b1;
                domain_state_nxt = DOM_TRANS;
            end
            default: begin
                clk_en_nxt       = 1'b1;
                domain_state_nxt = DOM_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_power_sequencer.sv
// Scoreboard bench for power_sequencer: expected output vectors are queued as
// each cycle's stimulus is driven and popped after the edge that consumes it.
module tb_power_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] power_mode;
    logic       pwr_ack;
    logic       clk_en;
    logic       iso_en;
    logic       save;
    logic       restore;
    logic       pwr_req;
    logic       seq_busy;
    logic [1:0] domain_state;
    logic       err;

    // {clk_en, iso_en, save, restore, pwr_req, seq_busy, domain_state, err}
    localparam logic [8:0] E_RUN     = 9'b1_0_0_0_1_0_00_0;
    localparam logic [8:0] E_GATED   = 9'b0_0_0_0_1_0_01_0;
    localparam logic [8:0] E_ISO_ON  = 9'b0_1_0_0_1_1_11_0;
    localparam logic [8:0] E_SAVE    = 9'b0_1_1_0_1_1_11_0;
    localparam logic [8:0] E_PWR_DN  = 9'b0_1_0_0_0_1_11_0;
    localparam logic [8:0] E_OFF     = 9'b0_1_0_0_0_0_10_0;
    localparam logic [8:0] E_PWR_UP  = 9'b0_1_0_0_1_1_11_0;
    localparam logic [8:0] E_RESTORE = 9'b0_1_0_1_1_1_11_0;
    localparam logic [8:0] E_ISO_OFF = 9'b0_0_0_0_1_1_11_0;
    localparam logic [8:0] E_ERR     = 9'b0_0_0_0_0_0_00_1;

    logic [8:0] exp_q [$];
    logic [8:0] exp_v;
    logic [8:0] obs_v;
    int         n_checks;
    int         n_pass;

    power_sequencer #(
        .STEP_CYCLES(2),
        .ACK_TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .power_mode  (power_mode),
        .pwr_ack     (pwr_ack),
        .clk_en      (clk_en),
        .iso_en      (iso_en),
        .save        (save),
        .restore     (restore),
        .pwr_req     (pwr_req),
        .seq_busy    (seq_busy),
        .domain_state(domain_state),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] sample();
        return {clk_en, iso_en, save, restore, pwr_req, seq_busy, domain_state, err};
    endfunction

    // Drive the inputs for the next edge and queue what that edge must produce.
    task automatic apply(input logic [1:0] mode, input logic ack, input logic [8:0] exp_out);
        power_mode = mode;
        pwr_ack    = ack;
        exp_q.push_back(exp_out);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apply(2'b00, 1'b0, E_RUN);
        #2;
        exp_v = exp_q.pop_front();
        obs_v = sample();
        n_checks++;
        if (obs_v !== exp_v) $display("FAIL reset_async got %b expected %b", obs_v, exp_v);
        else n_pass++;
        apply(2'b00, 1'b0, E_RUN);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        obs_v = sample();
        n_checks++;
        if (obs_v !== exp_v) $display("FAIL reset_held got %b expected %b", obs_v, exp_v);
        else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(2'b00, (i == 2), E_RUN);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            obs_v = sample();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL reset_release[%0d] got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_idle_gating();
        logic [1:0] md [5] = '{2'b01, 2'b01, 2'b00, 2'b11, 2'b00};
        logic [8:0] ex [5] = '{E_GATED, E_GATED, E_RUN, E_RUN, E_RUN};
        for (int i = 0; i < 5; i++) begin
            apply(md[i], 1'b1, ex[i]);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            obs_v = sample();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL idle_gating[%0d] got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_power_down();
        logic [1:0] md [8] = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        logic       ak [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [8:0] ex [8] = '{E_ISO_ON, E_ISO_ON, E_SAVE, E_SAVE,
                               E_PWR_DN, E_PWR_DN, E_OFF, E_OFF};
        for (int i = 0; i < 8; i++) begin
            apply(md[i], ak[i], ex[i]);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            obs_v = sample();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL power_down[%0d] got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_power_up();
        logic [1:0] md [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        logic       ak [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [8:0] ex [9] = '{E_PWR_UP, E_PWR_UP, E_PWR_UP, E_RESTORE, E_RESTORE,
                               E_ISO_OFF, E_ISO_OFF, E_RUN, E_RUN};
        for (int i = 0; i < 9; i++) begin
            apply(md[i], ak[i], ex[i]);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            obs_v = sample();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL power_up[%0d] got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    // Full down/up cycle with SLEEP held at the ISO_OFF exit, ending in PWR_DN.
    task automatic test_resleep();
        logic [1:0] md [16] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00,
                                2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        logic       ak [16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [8:0] ex [16] = '{E_ISO_ON, E_ISO_ON, E_SAVE, E_SAVE, E_PWR_DN, E_OFF,
                                E_PWR_UP, E_RESTORE, E_RESTORE, E_ISO_OFF, E_ISO_OFF,
                                E_ISO_ON, E_ISO_ON, E_SAVE, E_SAVE, E_PWR_DN};
        for (int i = 0; i < 16; i++) begin
            apply(md[i], ak[i], ex[i]);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            obs_v = sample();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL resleep[%0d] got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    // Entered PWR_DN on the previous edge; ack stays high past the 8-cycle limit.
    task automatic test_timeout();
        for (int i = 1; i <= 11; i++) begin
            if (i <= 7)       apply(2'b10, 1'b1, E_PWR_DN);
            else if (i <= 9)  apply(2'b10, 1'b1, E_PWR_DN | E_ERR);
            else              apply(2'b10, 1'b0, E_OFF | E_ERR);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            obs_v = sample();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL timeout[%0d] got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
        rst_n = 1'b0;
        apply(2'b10, 1'b0, E_RUN);
        #2;
        exp_v = exp_q.pop_front();
        obs_v = sample();
        n_checks++;
        if (obs_v !== exp_v) $display("FAIL timeout_reset got %b expected %b", obs_v, exp_v);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // GATED straight to sleep, then a reset in the middle of SAVE.
    task automatic test_gated_sleep_abort();
        logic [1:0] md [6] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
        logic [8:0] ex [6] = '{E_RUN, E_GATED, E_ISO_ON, E_ISO_ON, E_SAVE, E_SAVE};
        for (int i = 0; i < 6; i++) begin
            apply(md[i], 1'b1, ex[i]);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            obs_v = sample();
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL gated_sleep[%0d] got %b expected %b", i, obs_v, exp_v);
            else n_pass++;
        end
        rst_n = 1'b0;
        apply(2'b00, 1'b1, E_RUN);
        #2;
        exp_v = exp_q.pop_front();
        obs_v = sample();
        n_checks++;
        if (obs_v !== exp_v) $display("FAIL mid_seq_reset got %b expected %b", obs_v, exp_v);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(2'b00, 1'b1, E_RUN);
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        obs_v = sample();
        n_checks++;
        if (obs_v !== exp_v) $display("FAIL post_reset_run got %b expected %b", obs_v, exp_v);
        else n_pass++;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        power_mode = 2'b00;
        pwr_ack    = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_idle_gating();
        test_power_down();
        test_power_up();
        test_resleep();
        test_timeout();
        test_gated_sleep_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/power_sequencer.md
Name: power_sequencer

Overview:
- Consumes the 2-bit power_mode request from the power mode FSM and drives one switchable power domain.
- Sequences the domain controls in a fixed order: clock gate, isolation, retention save/restore, power switch request.
- Handshakes with the power switch through pwr_ack and flags a sticky error on acknowledge timeout.

Parameters:
- STEP_CYCLES, 2: cycles each timed step holds (ISO_ON, SAVE, RESTORE, ISO_OFF); must be >= 1.
- ACK_TIMEOUT, 64: cycles allowed in a wait-for-ack state before err is set; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- power_mode  input  2  requested mode: 00 ACTIVE, 01 IDLE, 10 SLEEP; 11 treated as ACTIVE.
- pwr_ack  input  1  power switch status: 1 = domain powered, 0 = domain off.
- clk_en  output  1  domain clock enable.
- iso_en  output  1  output isolation enable.
- save  output  1  retention save strobe.
- restore  output  1  retention restore strobe.
- pwr_req  output  1  power switch request: 1 = on.
- seq_busy  output  1  high in any transitional state.
- domain_state  output  2  00 RUN, 01 GATED, 10 OFF, 11 transitioning.
- err  output  1  sticky acknowledge-timeout flag.

Behaviour:
- All outputs are registered and change on the same edge as the state register.
- Reset values: state RUN, clk_en=1, iso_en=0, save=0, restore=0, pwr_req=1, seq_busy=0, domain_state=00, err=0.
- Reset mid-sequence returns to RUN immediately, regardless of pwr_ack.
- States and outputs (clk_en/iso_en/save/restore/pwr_req):
  - RUN 1/0/0/0/1.
  - GATED 0/0/0/0/1.
  - ISO_ON 0/1/0/0/1.
  - SAVE 0/1/1/0/1.
  - PWR_DN 0/1/0/0/0.
  - OFF 0/1/0/0/0.
  - PWR_UP 0/1/0/0/1.
  - RESTORE 0/1/0/1/1.
  - ISO_OFF 0/0/0/0/1.
- Transitions:
  - RUN: mode IDLE -> GATED; mode SLEEP -> ISO_ON.
  - GATED: mode ACTIVE/11 -> RUN; mode SLEEP -> ISO_ON.
  - ISO_ON -> SAVE after exactly STEP_CYCLES cycles.
  - SAVE -> PWR_DN after exactly STEP_CYCLES cycles.
  - PWR_DN -> OFF on the first edge sampling pwr_ack=0.
  - OFF: mode not SLEEP -> PWR_UP.
  - PWR_UP -> RESTORE on the first edge sampling pwr_ack=1.
  - RESTORE -> ISO_OFF after exactly STEP_CYCLES cycles.
  - ISO_OFF, after exactly STEP_CYCLES cycles: mode ACTIVE/11 -> RUN; IDLE -> GATED; SLEEP -> ISO_ON.
- power_mode is sampled only in RUN, GATED, OFF and at ISO_OFF exit. Sequences are non-abortable; mode changes mid-sequence are ignored until the next sampling point.
- Latency: a mode change sampled at edge N puts the new state and outputs into effect after edge N.
- Wait states have a minimum residency of 1 cycle. The step counter and timeout counter clear on every state entry.
- Timeout:
  - If a wait state has not exited after ACK_TIMEOUT cycles, err sets on that edge.
  - The FSM keeps waiting.
  - err clears only on reset.
- seq_busy=1 and domain_state=11 in ISO_ON, SAVE, PWR_DN, PWR_UP, RESTORE, ISO_OFF.
- Invalid state encoding -> RUN on the next edge.

Test Plan:
- STEP_CYCLES=2, ACK_TIMEOUT=8 for all scenarios.
- Reset: rst_n low with pwr_ack=0 -> outputs 1/0/0/0/1, domain_state=00, err=0; release with mode=00 -> stays RUN.
- Idle gating: in RUN set mode=01 at edge N -> clk_en=0, domain_state=01 after N; set mode=00 at edge M -> clk_en=1, domain_state=00 after M.
- Power-down: in RUN set mode=10 at edge 0, then pwr_ack drops to 0 one cycle after pwr_req falls:
  - iso_en=1 after edge 0.
  - save=1 after edges 2-3.
  - pwr_req=0 after edge 4.
  - OFF (domain_state=10, seq_busy=0) after the first edge sampling ack=0.
- Power-up: in OFF set mode=00, ack rises 3 cycles after pwr_req:
  - pwr_req=1 next edge.
  - restore=1 for 2 cycles after ack is sampled.
  - iso_en=0 for 2 cycles, then clk_en=1 in RUN.
  - Toggling mode to 10 during RESTORE is ignored.
- Re-sleep: mode=10 held while finishing ISO_OFF -> goes directly to ISO_ON, clk_en never asserts.
- Timeout: hold pwr_ack=1 in PWR_DN -> err=1 after 8 cycles, state stays PWR_DN; later ack=0 -> OFF with err still 1; assert rst_n low -> err=0, RUN.
